approx_mult_seq_ctrl: RTL and testbench

//  Sequential shift-add approximate multiplier with clock-gating control. Accepts an

---
 rtl/approx_mult_seq_ctrl_pkg.sv | 15 +
 rtl/approx_mult_seq_ctrl_adder.sv | 23 ++
 rtl/approx_mult_seq_ctrl.sv | 102 ++++++++++
 tb/tb_approx_mult_seq_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/approx_mult_seq_ctrl_pkg.sv
// Shared definitions for the approximate shift-add multiplier: FSM state
// encodings and default sizing used by the controller and its bench.
package approx_mult_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_W           = 8;
  localparam int DEF_APPROX_BITS = 4;
  localparam int DEF_SKIP_W      = 16;

endpackage

// File: rtl/approx_mult_seq_ctrl_adder.sv
// Approximate adder: carry-free OR on the low K bits, exact add above them.
// The low field never carries into the upper field, so the result never exceeds x+y.
module approx_adder_2w #(
  parameter int N = 16,
  parameter int K = 4
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] r
);

  generate
    if (K == 0) begin : g_exact
      assign r = x + y;
    end else if (K >= N) begin : g_or
      assign r = x | y;
    end else begin : g_split
      assign r[K-1:0] = x[K-1:0] | y[K-1:0];
      assign r[N-1:K] = x[N-1:K] + y[N-1:K];
    end
  endgenerate

endmodule

// File: rtl/approx_mult_seq_ctrl.sv
// Sequential LSB-first shift-add approximate multiplier. acc_en drives the
// accumulator clock gate and is high only on RUN cycles that actually add.
//
// state   | meaning
// IDLE    | waiting for an operand pair, in_ready high
// RUN     | one multiplier bit per cycle, exits after the highest set bit
// DONE    | product held with out_valid until out_ready
module approx_mult_seq_ctrl
  import approx_mult_seq_ctrl_pkg::*;
#(
  parameter int W           = DEF_W,
  parameter int APPROX_BITS = DEF_APPROX_BITS,
  parameter int SKIP_W      = DEF_SKIP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      a,
  input  logic [W-1:0]      b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*W-1:0]    product,
  output logic              acc_en,
  output logic              busy,
  output logic [SKIP_W-1:0] skip_cnt
);

  localparam int CW = $clog2(W);

  state_t          state;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [CW-1:0]   cnt;
  logic [2*W-1:0]  acc;
  logic [2*W-1:0]  pp;
  logic [2*W-1:0]  sum;
  logic [W-1:0]    b_tail;
  logic            last_bit;

  // Remaining multiplier bits from the current position; bit 0 is this cycle's bit.
  assign b_tail   = b_reg >> cnt;
  assign last_bit = ((b_tail >> 1) == '0);
  assign pp       = {{W{1'b0}}, a_reg} << cnt;

  approx_adder_2w #(
    .N (2*W),
    .K (APPROX_BITS)
  ) u_adder (
    .x (acc),
    .y (pp),
    .r (sum)
  );

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign acc_en    = (state == ST_RUN) & b_tail[0];
  assign product   = acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      cnt      <= '0;
      acc      <= '0;
      skip_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= '0;
            cnt   <= '0;
            state <= ((a == '0) || (b == '0)) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (b_tail[0]) begin
            acc <= sum;
          end else if (skip_cnt != '1) begin
            skip_cnt <= skip_cnt + SKIP_W'(1);
          end
          if (last_bit) begin
            state <= ST_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_mult_seq_ctrl.sv
// Bench: two instances (APPROX_BITS=4 and exact) share stimulus; results are
// compared against an arithmetic reference model of the approximate product.
module tb_approx_mult_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  a, b;
  logic        out_ready;

  logic        in_ready4, out_valid4, acc_en4, busy4;
  logic [15:0] product4, skip4;
  logic        in_ready0, out_valid0, acc_en0, busy0;
  logic [15:0] product0, skip0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  approx_mult_seq_ctrl #(.W(8), .APPROX_BITS(4), .SKIP_W(16)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a), .b(b), .out_valid(out_valid4), .out_ready(out_ready),
    .product(product4), .acc_en(acc_en4), .busy(busy4), .skip_cnt(skip4));

  approx_mult_seq_ctrl #(.W(8), .APPROX_BITS(0), .SKIP_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
    .product(product0), .acc_en(acc_en0), .busy(busy0), .skip_cnt(skip0));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: sum partial products a<<i for set bits of b; low k bits combine by OR,
  // upper bits by ordinary addition modulo the upper-field width.
  function automatic int ref_prod(input int av, input int bv, input int k);
    int acc, pp, lo, hi;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (((bv >> i) & 1) == 1) begin
        pp = (av << i) & 32'hFFFF;
        if (k == 0) begin
          acc = (acc + pp) & 32'hFFFF;
        end else begin
          lo  = (acc | pp) % (1 << k);
          hi  = ((acc >> k) + (pp >> k)) % (1 << (16 - k));
          acc = (hi << k) + lo;
        end
      end
    end
    return acc;
  endfunction

  function automatic int high_bit(input int bv);
    int m;
    m = -1;
    for (int i = 0; i < 8; i++) if (((bv >> i) & 1) == 1) m = i;
    return m;
  endfunction

  function automatic int popcnt(input int bv);
    int c;
    c = 0;
    for (int i = 0; i < 8; i++) c += (bv >> i) & 1;
    return c;
  endfunction

  // One transaction; hold = cycles out_ready stays low once DONE is reached.
  task automatic do_op(input int av, input int bv, input int hold, input bit full);
    int n, m, exp_lat, exp_skip, en_err, skip_before;
    m        = high_bit(bv);
    exp_lat  = (av == 0 || bv == 0) ? 0 : m + 1;
    exp_skip = (av == 0 || bv == 0) ? 0 : (m + 1 - popcnt(bv));
    skip_before = skip4;
    a = av[7:0];
    b = bv[7:0];
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    n = 0;
    en_err = 0;
    while (!out_valid4 && n < 40) begin
      if (acc_en4 !== bv[n % 8]) en_err++;
      if (busy4 !== 1'b1) en_err++;
      step();
      n++;
    end
    if (full) begin
      check("latency", n, exp_lat);
      check("acc_en_pattern", en_err, 0);
      check("acc_en_done", acc_en4, 1'b0);
      check("skip_delta", skip4 - skip_before, exp_skip);
    end
    check("product_k4", product4, ref_prod(av, bv, 4));
    check("product_k0", product0, ref_prod(av, bv, 0));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      step();
      check("hold_valid", out_valid4, 1'b1);
      check("hold_in_ready", in_ready4, 1'b0);
      check("hold_product", product4, ref_prod(av, bv, 4));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    if (full) begin
      check("release_in_ready", in_ready4, 1'b1);
      check("release_valid", out_valid4, 1'b0);
    end
  endtask

  initial begin
    int ra, rb, sk;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_in_ready", in_ready4, 1'b1);
    check("rst_out_valid", out_valid4, 1'b0);
    check("rst_busy", busy4, 1'b0);
    check("rst_acc_en", acc_en4, 1'b0);
    check("rst_product", product4, 0);
    check("rst_skip", skip4, 0);

    do_op(3, 5, 0, 1'b1);
    check("skip_after_3x5", skip4, 1);
    do_op(15, 3, 0, 1'b1);
    check("prod_15x3", product4, 31);
    do_op(200, 0, 0, 1'b1);
    do_op(0, 77, 0, 1'b1);
    do_op(1, 8'h80, 0, 1'b1);
    check("prod_1x128", product4, 128);
    check("skip_after_1x128", skip4, 8);
    do_op(255, 255, 5, 1'b1);
    check("prod_255x255_exact", product0, 65025);

    // Abort mid-operation: reset at RUN n=2.
    a = 8'd1; b = 8'h80; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("pre_abort_busy", busy4, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_in_ready", in_ready4, 1'b1);
    check("abort_busy", busy4, 1'b0);
    check("abort_product", product4, 0);
    check("abort_skip", skip4, 0);

    for (int i = 0; i < 500; i++) begin
      ra = int'($urandom_range(0, 255));
      rb = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 255));
      do_op(ra, rb, int'($urandom_range(0, 2)), (i % 10) == 0);
    end
    sk = skip0;
    check("skip_match_instances", skip4, sk[15:0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
